// File: rtl/multicycle_control.sv
// Multicycle processor control unit: an eight-state FSM whose Moore outputs
// drive the datapath, with optional wait-for-memory handshake in FETCH and MEM.
module multicycle_control #(
  parameter int ALUOP_WIDTH = 5,
  parameter bit MEM_WAIT    = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             OP,
  input  logic                   mem_ready,
  output logic                   PCWrite,
  output logic                   IRWrite,
  output logic                   IorD,
  output logic                   RegDst,
  output logic                   ALUSrcA,
  output logic                   MemtoReg,
  output logic                   RegWrite,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic [1:0]             ALUSrcB,
  output logic                   BranchEQ,
  output logic                   BranchNE,
  output logic                   Jump,
  output logic [ALUOP_WIDTH-1:0] ALUOp,
  output logic                   retire,
  output logic                   illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ = 6'h04,
                         OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0c,
                         OP_ORI   = 6'h0d, OP_LUI  = 6'h0f, OP_LW  = 6'h23,
                         OP_SW    = 6'h2b;

  state_t     r_state;
  logic       w_mem_done;
  logic       w_exec_op;
  logic       w_branch_op;
  logic [3:0] w_aluop;

  function automatic logic [3:0] exec_aluop(input logic [5:0] op);
    case (op)
      OP_RTYPE: exec_aluop = 4'd7;
      OP_ADDI:  exec_aluop = 4'd1;
      OP_ANDI:  exec_aluop = 4'd2;
      OP_ORI:   exec_aluop = 4'd3;
      OP_LUI:   exec_aluop = 4'd4;
      OP_LW:    exec_aluop = 4'd5;
      OP_SW:    exec_aluop = 4'd6;
      default:  exec_aluop = 4'd0;
    endcase
  endfunction

  // With MEM_WAIT=0 every memory access is taken to finish in one cycle.
  assign w_mem_done  = mem_ready || (MEM_WAIT == 1'b0);
  assign w_exec_op   = (OP == OP_RTYPE) || (OP == OP_ADDI) || (OP == OP_ANDI) ||
                       (OP == OP_ORI) || (OP == OP_LUI) || (OP == OP_LW) ||
                       (OP == OP_SW);
  assign w_branch_op = (OP == OP_BEQ) || (OP == OP_BNE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH:  if (w_mem_done) r_state <= S_DECODE;
        S_DECODE: begin
          if (w_exec_op)        r_state <= S_EXEC;
          else if (w_branch_op) r_state <= S_BRANCH;
          else if (OP == OP_J)  r_state <= S_JUMP;
          else                  r_state <= S_FETCH;
        end
        S_EXEC:   r_state <= ((OP == OP_LW) || (OP == OP_SW)) ? S_MEM : S_WB;
        S_MEM:    if (w_mem_done) r_state <= (OP == OP_LW) ? S_WB : S_FETCH;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    RegDst   = 1'b0;
    ALUSrcA  = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUSrcB  = 2'd0;
    BranchEQ = 1'b0;
    BranchNE = 1'b0;
    Jump     = 1'b0;
    retire   = 1'b0;
    illegal  = 1'b0;
    w_aluop  = 4'd0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        w_aluop = 4'd1;
        IRWrite = w_mem_done;
        PCWrite = w_mem_done;
      end
      S_DECODE: begin
        ALUSrcB = 2'd3;
        w_aluop = 4'd1;
        illegal = !(w_exec_op || w_branch_op || (OP == OP_J));
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = (OP == OP_RTYPE) ? 2'd0 : 2'd2;
        w_aluop = exec_aluop(OP);
      end
      S_MEM: begin
        IorD     = 1'b1;
        MemRead  = (OP == OP_LW);
        MemWrite = (OP == OP_SW);
        retire   = (OP == OP_SW) && w_mem_done;
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = (OP == OP_RTYPE);
        MemtoReg = (OP == OP_LW);
        retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        w_aluop  = (OP == OP_BEQ) ? 4'd9 : 4'd8;
        BranchEQ = (OP == OP_BEQ);
        BranchNE = (OP == OP_BNE);
        retire   = 1'b1;
      end
      S_JUMP: begin
        Jump    = 1'b1;
        PCWrite = 1'b1;
        retire  = 1'b1;
      end
      default: ;
    endcase
    ALUOp = ALUOP_WIDTH'(w_aluop);
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle vectors for a
// MEM_WAIT=1 instance and a MEM_WAIT=0 instance with mem_ready tied low.
module tb_multicycle_control;

  localparam logic [13:0] PCW = 14'h0001, IRW = 14'h0002, IORD = 14'h0004,
                          RDST = 14'h0008, SRCA = 14'h0010, M2R = 14'h0020,
                          RW  = 14'h0040, MR  = 14'h0080, MW   = 14'h0100,
                          BEQ = 14'h0200, BNE = 14'h0400, JMP  = 14'h0800,
                          RET = 14'h1000, ILL = 14'h2000;

  typedef struct packed {
    logic        sel;
    logic [4:0]  aluop;
    logic [1:0]  srcb;
    logic [13:0] flags;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] op_a, op_b;
  logic mr_a;

  logic a_pcw, a_irw, a_iord, a_rdst, a_srca, a_m2r, a_rw, a_mr, a_mw;
  logic a_beq, a_bne, a_jmp, a_ret, a_ill;
  logic [1:0] a_srcb;
  logic [4:0] a_aluop;
  logic b_pcw, b_irw, b_iord, b_rdst, b_srca, b_m2r, b_rw, b_mr, b_mw;
  logic b_beq, b_bne, b_jmp, b_ret, b_ill;
  logic [1:0] b_srcb;
  logic [4:0] b_aluop;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_control #(.ALUOP_WIDTH(5), .MEM_WAIT(1'b1)) dut_a (
    .clk(clk), .reset(reset), .OP(op_a), .mem_ready(mr_a),
    .PCWrite(a_pcw), .IRWrite(a_irw), .IorD(a_iord), .RegDst(a_rdst),
    .ALUSrcA(a_srca), .MemtoReg(a_m2r), .RegWrite(a_rw), .MemRead(a_mr),
    .MemWrite(a_mw), .ALUSrcB(a_srcb), .BranchEQ(a_beq), .BranchNE(a_bne),
    .Jump(a_jmp), .ALUOp(a_aluop), .retire(a_ret), .illegal(a_ill)
  );

  multicycle_control #(.ALUOP_WIDTH(5), .MEM_WAIT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .OP(op_b), .mem_ready(1'b0),
    .PCWrite(b_pcw), .IRWrite(b_irw), .IorD(b_iord), .RegDst(b_rdst),
    .ALUSrcA(b_srca), .MemtoReg(b_m2r), .RegWrite(b_rw), .MemRead(b_mr),
    .MemWrite(b_mw), .ALUSrcB(b_srcb), .BranchEQ(b_beq), .BranchNE(b_bne),
    .Jump(b_jmp), .ALUOp(b_aluop), .retire(b_ret), .illegal(b_ill)
  );

  // Monitor: every negedge with a pending expectation is one compared vector.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [20:0] act, req;
      e = q.pop_front();
      if (e.sel == 1'b0)
        act = {a_aluop, a_srcb, a_ill, a_ret, a_jmp, a_bne, a_beq, a_mw, a_mr,
               a_rw, a_m2r, a_srca, a_iord == 1'b1 ? 1'b1 : 1'b0, a_rdst, a_irw, a_pcw};
      else
        act = {b_aluop, b_srcb, b_ill, b_ret, b_jmp, b_bne, b_beq, b_mw, b_mr,
               b_rw, b_m2r, b_srca, b_iord, b_rdst, b_irw, b_pcw};
      // Swap IorD/RegDst back into flag order (bit2 IorD, bit3 RegDst).
      act = {act[20:4], act[2], act[3], act[1:0]};
      req = {e.aluop, e.srcb, e.flags};
      vectors++;
      if (act !== req) begin
        miscompares++;
        $display("FAIL vec%0d dut_%s: got aluop=%0d srcb=%0d flags=%h, want aluop=%0d srcb=%0d flags=%h",
                 vectors, e.sel ? "b" : "a", act[20:16], act[15:14], act[13:0],
                 e.aluop, e.srcb, e.flags);
      end
    end
  end

  task automatic cyc(input logic rst, input logic [5:0] op, input logic mr,
                     input logic [13:0] fl, input logic [1:0] sb,
                     input logic [4:0] al, input logic sel);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    if (sel) op_b = op; else op_a = op;
    mr_a = mr;
    e.sel = sel; e.aluop = al; e.srcb = sb; e.flags = fl;
    q.push_back(e);
  endtask

  task automatic fetch_ok(input logic [5:0] op, input logic sel);
    cyc(1'b1, op, 1'b1, MR | IRW | PCW, 2'd1, 5'd1, sel);
  endtask

  task automatic decode(input logic [5:0] op, input logic sel);
    cyc(1'b1, op, 1'b0, 14'h0, 2'd3, 5'd1, sel);
  endtask

  initial begin
    reset = 1'b1;
    op_a = 6'h00;
    op_b = 6'h2b;
    mr_a = 1'b1;
    #2 reset = 1'b0;

    // Reset held, then released: IDLE with all outputs zero.
    cyc(1'b0, 6'h00, 1'b1, 14'h0, 2'd0, 5'd0, 1'b0);
    cyc(1'b1, 6'h00, 1'b1, 14'h0, 2'd0, 5'd0, 1'b0);
    // R-type.
    fetch_ok(6'h00, 1'b0);
    decode(6'h00, 1'b0);
    cyc(1'b1, 6'h00, 1'b1, SRCA, 2'd0, 5'd7, 1'b0);
    cyc(1'b1, 6'h00, 1'b1, RW | RDST | RET, 2'd0, 5'd0, 1'b0);
    // LW with three stall cycles in MEM.
    fetch_ok(6'h23, 1'b0);
    decode(6'h23, 1'b0);
    cyc(1'b1, 6'h23, 1'b1, SRCA, 2'd2, 5'd5, 1'b0);
    cyc(1'b1, 6'h23, 1'b0, IORD | MR, 2'd0, 5'd0, 1'b0);
    cyc(1'b1, 6'h23, 1'b0, IORD | MR, 2'd0, 5'd0, 1'b0);
    cyc(1'b1, 6'h23, 1'b0, IORD | MR, 2'd0, 5'd0, 1'b0);
    cyc(1'b1, 6'h23, 1'b1, IORD | MR, 2'd0, 5'd0, 1'b0);
    cyc(1'b1, 6'h23, 1'b1, RW | M2R | RET, 2'd0, 5'd0, 1'b0);
    // BNE, with one FETCH stall cycle first.
    cyc(1'b1, 6'h05, 1'b0, MR, 2'd1, 5'd1, 1'b0);
    fetch_ok(6'h05, 1'b0);
    decode(6'h05, 1'b0);
    cyc(1'b1, 6'h05, 1'b1, SRCA | BNE | RET, 2'd0, 5'd8, 1'b0);
    // BEQ.
    fetch_ok(6'h04, 1'b0);
    decode(6'h04, 1'b0);
    cyc(1'b1, 6'h04, 1'b1, SRCA | BEQ | RET, 2'd0, 5'd9, 1'b0);
    // J.
    fetch_ok(6'h02, 1'b0);
    decode(6'h02, 1'b0);
    cyc(1'b1, 6'h02, 1'b1, JMP | PCW | RET, 2'd0, 5'd0, 1'b0);
    // Illegal opcode returns straight to FETCH.
    fetch_ok(6'h3f, 1'b0);
    cyc(1'b1, 6'h3f, 1'b1, ILL, 2'd3, 5'd1, 1'b0);
    // ORI.
    fetch_ok(6'h0d, 1'b0);
    decode(6'h0d, 1'b0);
    cyc(1'b1, 6'h0d, 1'b1, SRCA, 2'd2, 5'd3, 1'b0);
    cyc(1'b1, 6'h0d, 1'b1, RW | RET, 2'd0, 5'd0, 1'b0);
    // SW stalled in MEM, then reset lands mid-access.
    fetch_ok(6'h2b, 1'b0);
    decode(6'h2b, 1'b0);
    cyc(1'b1, 6'h2b, 1'b1, SRCA, 2'd2, 5'd6, 1'b0);
    cyc(1'b1, 6'h2b, 1'b0, IORD | MW, 2'd0, 5'd0, 1'b0);
    cyc(1'b0, 6'h2b, 1'b0, 14'h0, 2'd0, 5'd0, 1'b0);
    cyc(1'b0, 6'h2b, 1'b1, 14'h0, 2'd0, 5'd0, 1'b0);
    cyc(1'b1, 6'h2b, 1'b1, 14'h0, 2'd0, 5'd0, 1'b0);
    // SW completing normally.
    fetch_ok(6'h2b, 1'b0);
    decode(6'h2b, 1'b0);
    cyc(1'b1, 6'h2b, 1'b1, SRCA, 2'd2, 5'd6, 1'b0);
    cyc(1'b1, 6'h2b, 1'b1, IORD | MW | RET, 2'd0, 5'd0, 1'b0);
    // ADDI, with mem_ready low outside FETCH/MEM.
    fetch_ok(6'h08, 1'b0);
    cyc(1'b1, 6'h08, 1'b0, 14'h0, 2'd3, 5'd1, 1'b0);
    cyc(1'b1, 6'h08, 1'b0, SRCA, 2'd2, 5'd1, 1'b0);
    cyc(1'b1, 6'h08, 1'b0, RW | RET, 2'd0, 5'd0, 1'b0);

    // MEM_WAIT=0 instance: SW completes with mem_ready tied low.
    cyc(1'b0, 6'h2b, 1'b0, 14'h0, 2'd0, 5'd0, 1'b1);
    cyc(1'b1, 6'h2b, 1'b0, 14'h0, 2'd0, 5'd0, 1'b1);
    cyc(1'b1, 6'h2b, 1'b0, MR | IRW | PCW, 2'd1, 5'd1, 1'b1);
    cyc(1'b1, 6'h2b, 1'b0, 14'h0, 2'd3, 5'd1, 1'b1);
    cyc(1'b1, 6'h2b, 1'b0, SRCA, 2'd2, 5'd6, 1'b1);
    cyc(1'b1, 6'h2b, 1'b0, IORD | MW | RET, 2'd0, 5'd0, 1'b1);
    cyc(1'b1, 6'h2b, 1'b0, MR | IRW | PCW, 2'd1, 5'd1, 1'b1);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALUOP_WIDTH, default 5: width of ALUOp; SHALL be >= 4.
REQ-002 Parameter MEM_WAIT, default 1: 1 = memory states hold until mem_ready; 0 = mem_ready ignored, memory assumed single-cycle.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 OP  in  6  opcode from instruction register; stable from DECODE until the next FETCH.
REQ-006 mem_ready  in  1  memory access completes this cycle.
REQ-007 PCWrite, IRWrite, IorD  out  1 each  PC load, IR load, address select (0 = PC, 1 = ALUOut).
REQ-008 RegDst, ALUSrcA, MemtoReg, RegWrite, MemRead, MemWrite  out  1 each  datapath controls.
REQ-009 ALUSrcB  out  2  ALU B select: 0 = reg, 1 = const 4, 2 = sign-ext imm, 3 = imm<<2.
REQ-010 BranchEQ, BranchNE, Jump  out  1 each  conditional/unconditional PC update qualifiers.
REQ-011 ALUOp  out  ALUOP_WIDTH  ALU operation code, zero-extended.
REQ-012 retire, illegal  out  1 each  one-cycle pulse on instruction completion / unknown opcode.

Function
REQ-013 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP.
REQ-014 IDLE -> FETCH unconditionally.
REQ-015 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=1; stay until mem_ready (or 1 cycle if MEM_WAIT=0); in the exit cycle only: IRWrite=1, PCWrite=1; -> DECODE.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=1 (branch target precompute); next state by OP: 0x00, 0x08, 0x0c, 0x0d, 0x0f, 0x23, 0x2b -> EXEC; 0x04, 0x05 -> BRANCH; 0x02 -> JUMP; any other -> FETCH with illegal=1 for that cycle.
REQ-017 EXEC: ALUSrcA=1; ALUSrcB=0 for R-type, else 2; ALUOp per REQ-018; 0x23/0x2b -> MEM, all others -> WB.
REQ-018 ALUOp codes: R-type 7, ADDI 1, ANDI 2, ORI 3, LUI 4, LW 5, SW 6, BEQ 9, BNE 8; in IDLE/WB/MEM/JUMP ALUOp=0.
REQ-019 MEM: IorD=1; MemRead=1 for 0x23, MemWrite=1 for 0x2b; hold until mem_ready (MEM_WAIT=1); 0x23 -> WB; 0x2b -> FETCH with retire=1.
REQ-020 WB: RegWrite=1; RegDst=1 only for R-type; MemtoReg=1 only for 0x23; -> FETCH with retire=1.
REQ-021 BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=9 (0x04) or 8 (0x05); BranchEQ=1 for 0x04, BranchNE=1 for 0x05; one cycle; -> FETCH with retire=1.
REQ-022 JUMP: Jump=1, PCWrite=1 for one cycle; -> FETCH with retire=1.
REQ-023 All outputs not listed as asserted in a state SHALL be 0 in that state.
REQ-024 Outputs SHALL be Moore outputs of state and OP (plus mem_ready for IRWrite/PCWrite in FETCH); no output from an unlisted state/opcode pair.
REQ-025 MemRead and MemWrite SHALL never be 1 in the same cycle; RegWrite only in WB.
REQ-026 mem_ready outside FETCH/MEM SHALL be ignored.

Reset
REQ-027 reset=0 SHALL force state IDLE immediately (asynchronously), mid-instruction included, abandoning any pending access.
REQ-028 While reset=0 and in IDLE, every output SHALL be 0.
REQ-029 First rising edge after reset deasserts SHALL move IDLE -> FETCH.

Verification
REQ-030 Reset release, mem_ready=1, OP=0x00 -> IDLE, FETCH, DECODE, EXEC(ALUOp=7, ALUSrcB=0), WB(RegWrite=1, RegDst=1), retire on the WB -> FETCH transition.
REQ-031 OP=0x23, mem_ready low 3 cycles in MEM -> MemRead=1, IorD=1 held 4 cycles, then WB with MemtoReg=1.
REQ-032 OP=0x05 -> DECODE(ALUSrcB=3), BRANCH(BranchNE=1, ALUOp=8) one cycle, FETCH; OP=0x02 -> JUMP with Jump=1, PCWrite=1.
REQ-033 OP=0x3f in DECODE -> illegal=1 for one cycle, next state FETCH, no RegWrite/MemWrite asserted.
REQ-034 reset asserted during MEM of OP=0x2b -> MemWrite=0 within the same cycle, all outputs 0, IDLE then FETCH after release.
REQ-035 MEM_WAIT=0, mem_ready tied 0, OP=0x2b -> FETCH, DECODE, EXEC, MEM each exactly one cycle; retire on the MEM -> FETCH transition.
